// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Owns the 32-bit PC, the two-word reset-vector boot sequence, PC source
// selection, the IF/ID pipeline register and the interrupt-pending latch.
// Build option: define FETCH_INT_SYNC_EN to pass int_req through a two-flop
// synchronizer before edge detection; otherwise int_req is edge-detected
// directly.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] jump_target,
  input  logic        fetch_pc_enable,
  input  logic        freeze_cu,
  input  logic        flush_fetch,
  input  logic        pop_pc2,
  input  logic        pop_pc1,
  input  logic [15:0] pop_data,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        int_req,
  input  logic        int_ack,
  output logic        int_pending,
  output logic [15:0] if_id_instr,
  output logic [4:0]  opCode,
  output logic [31:0] if_id_pc_next,
  output logic        boot_busy
);

  localparam logic [31:0] INT_VECTOR = 32'h0000_0010;
  localparam logic [15:0] NOP_WORD   = 16'h0000;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_REBOOT = 2'b01;
  localparam logic [1:0] SEL_INT    = 2'b10;
  localparam logic [1:0] SEL_JUMP   = 2'b11;

  typedef enum logic [1:0] {
    BOOT_HI = 2'b00,
    BOOT_LO = 2'b01,
    RUN     = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] staged_hi_q, staged_hi_d;
  logic [15:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_next_q, if_id_pc_next_d;
  logic        int_prev_q;
  logic        int_pending_q, int_pending_d;
  logic        int_level;
  logic        int_rise;

  // Decodes produced by the FSM output process.
  logic        in_boot;
  logic        reboot;
  logic [31:0] pc_plus1;

  assign pc_plus1 = pc_q + 32'd1;

  // Boot FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT_HI;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples pre-edge values regardless of block evaluation order.
      state_q <= state_d;
    end
  end

  // Boot FSM next-state logic.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      BOOT_HI: state_d = BOOT_LO;
      BOOT_LO: state_d = RUN;
      RUN:     if (!pop_pc1 && pc_sel == SEL_REBOOT) state_d = BOOT_HI;
      default: state_d = BOOT_HI;
    endcase
  end

  // Boot FSM outputs.
  always_comb begin
    in_boot   = (state_q != RUN);
    boot_busy = in_boot;
    // A pop_pc1 outranks a reboot request, so the reboot only happens alone.
    reboot    = (state_q == RUN) && !pop_pc1 && (pc_sel == SEL_REBOOT);
  end

  // PC and staged high half: boot sequence, pops, jumps and sequential fetch.
  always_comb begin
    pc_d        = pc_q;
    staged_hi_d = staged_hi_q;

    if (state_q == BOOT_HI) staged_hi_d = imem_data;
    // A pop of the high half is honoured in every state.
    if (pop_pc2) staged_hi_d = pop_data;

    case (state_q)
      BOOT_HI: pc_d = 32'd1;
      BOOT_LO: pc_d = {staged_hi_q, imem_data};
      default: begin
        // Pops and pc_sel loads override a frozen PC: ret/rti pop while frozen.
        if (pop_pc1)                   pc_d = {staged_hi_q, pop_data};
        else if (pc_sel == SEL_JUMP)   pc_d = jump_target;
        else if (pc_sel == SEL_INT)    pc_d = INT_VECTOR;
        else if (reboot)               pc_d = 32'd0;
        else if (!fetch_pc_enable)     pc_d = pc_q;
        else                           pc_d = pc_plus1;
      end
    endcase
  end

  // IF/ID register next value: boot and flush inject a NOP, freeze holds.
  always_comb begin
    if_id_instr_d   = if_id_instr_q;
    if_id_pc_next_d = if_id_pc_next_q;
    if (in_boot || flush_fetch) begin
      if_id_instr_d   = NOP_WORD;
      if_id_pc_next_d = 32'd0;
    end else if (!freeze_cu) begin
      if_id_instr_d   = imem_data;
      if_id_pc_next_d = pc_plus1;
    end
  end

  // Datapath registers; reset aborts any boot, pop or jump in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q            <= 32'd0;
      staged_hi_q     <= 16'd0;
      if_id_instr_q   <= NOP_WORD;
      if_id_pc_next_q <= 32'd0;
    end else begin
      pc_q            <= pc_d;
      staged_hi_q     <= staged_hi_d;
      if_id_instr_q   <= if_id_instr_d;
      if_id_pc_next_q <= if_id_pc_next_d;
    end
  end

`ifdef FETCH_INT_SYNC_EN
  logic int_sync1_q, int_sync2_q;

  // Two-flop synchronizer bringing the asynchronous pin into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_sync1_q <= 1'b0;
      int_sync2_q <= 1'b0;
    end else begin
      int_sync1_q <= int_req;
      int_sync2_q <= int_sync1_q;
    end
  end

  assign int_level = int_sync2_q;
`else
  assign int_level = int_req;
`endif

  assign int_rise = int_level & ~int_prev_q;
  // A fresh edge wins over an acknowledge arriving in the same cycle.
  assign int_pending_d = int_rise | (int_pending_q & ~int_ack);

  // Edge-detect flop and pending latch; a level held high sets pending once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_prev_q    <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      int_prev_q    <= int_level;
      int_pending_q <= int_pending_d;
    end
  end

  assign imem_addr     = pc_q;
  assign if_id_instr   = if_id_instr_q;
  assign opCode        = if_id_instr_q[15:11];
  assign if_id_pc_next = if_id_pc_next_q;
  assign int_pending   = int_pending_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// The driver advances a behavioural model of the fetch stage each cycle and
// queues the expected outputs; a monitor on the falling edge pops and compares.
module tb_fetch_unit;

`ifdef FETCH_INT_SYNC_EN
  localparam int INT_LAT = 3;
`else
  localparam int INT_LAT = 1;
`endif
  localparam logic [31:0] INT_VECTOR = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [31:0] jump_target;
  logic        fetch_pc_enable;
  logic        freeze_cu;
  logic        flush_fetch;
  logic        pop_pc2;
  logic        pop_pc1;
  logic [15:0] pop_data;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        int_req;
  logic        int_ack;
  logic        int_pending;
  logic [15:0] if_id_instr;
  logic [4:0]  opCode;
  logic [31:0] if_id_pc_next;
  logic        boot_busy;

  logic [15:0] mem [0:1023];
  assign imem_data = mem[imem_addr[9:0]];

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .jump_target(jump_target),
    .fetch_pc_enable(fetch_pc_enable), .freeze_cu(freeze_cu),
    .flush_fetch(flush_fetch), .pop_pc2(pop_pc2), .pop_pc1(pop_pc1),
    .pop_data(pop_data), .imem_addr(imem_addr), .imem_data(imem_data),
    .int_req(int_req), .int_ack(int_ack), .int_pending(int_pending),
    .if_id_instr(if_id_instr), .opCode(opCode),
    .if_id_pc_next(if_id_pc_next), .boot_busy(boot_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] instr;
    logic [31:0] pcn;
    logic        pend;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model: words of the reset vector loaded so far (0,1,2=running).
  logic [31:0] m_pc, m_pcn;
  logic [15:0] m_hi, m_instr;
  int          m_boot;
  logic        m_pend;
  bit          hist[$];   // int_req as sampled at successive edges, newest first

  task automatic model_reset();
    m_pc = 0; m_hi = 0; m_boot = 0; m_instr = 0; m_pcn = 0; m_pend = 0;
    hist = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic model_advance();
    logic [15:0] w;
    logic [31:0] pc_n;
    logic [15:0] hi_n;
    int          boot_n;
    bit          rise;
    w = mem[m_pc[9:0]];
    hist.push_front(int_req);
    void'(hist.pop_back());
    rise   = hist[INT_LAT-1] && !hist[INT_LAT];
    m_pend = rise || (m_pend && !int_ack);
    if (m_boot < 2 || flush_fetch) begin
      m_instr = 16'h0000; m_pcn = 0;
    end else if (!freeze_cu) begin
      m_instr = w; m_pcn = m_pc + 1;
    end
    hi_n = m_hi;
    if (m_boot == 0) hi_n = w;
    if (pop_pc2) hi_n = pop_data;
    pc_n = m_pc; boot_n = m_boot;
    if (m_boot == 0) begin
      pc_n = 1; boot_n = 1;
    end else if (m_boot == 1) begin
      pc_n = {m_hi, w}; boot_n = 2;
    end else if (pop_pc1)        pc_n = {m_hi, pop_data};
    else if (pc_sel == 2'b11)    pc_n = jump_target;
    else if (pc_sel == 2'b10)    pc_n = INT_VECTOR;
    else if (pc_sel == 2'b01) begin
      pc_n = 0; boot_n = 0;
    end else if (fetch_pc_enable) pc_n = m_pc + 1;
    m_pc = pc_n; m_hi = hi_n; m_boot = boot_n;
  endtask

  // One clock cycle: queue the outputs expected now, advance the model with the
  // inputs currently driven, then move to just after the next rising edge.
  task automatic step();
    if (rst) model_reset();
    exp_q.push_back(exp_t'{addr: m_pc, instr: m_instr, pcn: m_pcn,
                           pend: m_pend, busy: (m_boot < 2)});
    if (!rst) model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    pc_sel = 2'b00; jump_target = 0; fetch_pc_enable = 1'b1; freeze_cu = 1'b0;
    flush_fetch = 1'b0; pop_pc2 = 1'b0; pop_pc1 = 1'b0; pop_data = 0; int_ack = 1'b0;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("imem_addr", imem_addr, e.addr);
      check("if_id_instr", if_id_instr, e.instr);
      check("opCode", opCode, e.instr[15:11]);
      check("if_id_pc_next", if_id_pc_next, e.pcn);
      check("int_pending", int_pending, e.pend);
      check("boot_busy", boot_busy, e.busy);
    end
  end

  initial begin
    logic [15:0] held;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0000;
    mem[1] = 16'h0020;
    int_req = 1'b0;
    set_idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;

    // Boot: two busy cycles, then PC at the reset vector.
    step();
    step();
    check("boot pc", imem_addr, 32'h20);
    check("boot done", boot_busy, 1'b0);
    step();
    step();
    check("first instr", if_id_instr, mem[16'h21]);

    // Jump with flush from PC 0x22.
    pc_sel = 2'b11; jump_target = 32'h100; flush_fetch = 1'b1;
    step();
    set_idle();
    check("jump pc", imem_addr, 32'h100);
    check("flush opCode", opCode, 5'd0);
    step();
    check("jump fetch", if_id_instr, mem[10'h100]);

    // Pop sequence while the PC is frozen.
    fetch_pc_enable = 1'b0; pop_pc2 = 1'b1; pop_data = 16'h0001;
    step();
    pop_pc2 = 1'b0; pop_pc1 = 1'b1; pop_data = 16'h0004;
    step();
    set_idle();
    check("pop pc", imem_addr, 32'h0001_0004);

    // Freeze holds IF/ID; flush beats freeze.
    step();
    held = m_instr;
    freeze_cu = 1'b1;
    step();
    step();
    check("freeze hold", if_id_instr, held);
    flush_fetch = 1'b1;
    step();
    set_idle();
    check("flush over freeze", if_id_instr, 16'h0000);

    // PC wraps from all-ones to zero.
    pc_sel = 2'b11; jump_target = 32'hFFFF_FFFF;
    step();
    set_idle();
    step();
    check("pc wrap", imem_addr, 32'h0);

    // Interrupt pulse, latency, acknowledge, level held high.
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    for (int i = 1; i < INT_LAT; i++) begin
      check("int early", int_pending, 1'b0);
      step();
    end
    check("int latency", int_pending, 1'b1);
    step();
    step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    check("int ack", int_pending, 1'b0);
    int_req = 1'b1;
    for (int i = 0; i < INT_LAT; i++) step();
    check("int held set", int_pending, 1'b1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("int held once", int_pending, 1'b0);
    int_req = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      int r;
      r = $urandom_range(0, 99);
      pc_sel          = (r < 6) ? 2'b11 : (r < 9) ? 2'b10 : (r < 11) ? 2'b01 : 2'b00;
      jump_target     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      flush_fetch     = (pc_sel == 2'b11) || ($urandom_range(0, 9) == 0);
      freeze_cu       = ($urandom_range(0, 7) == 0);
      fetch_pc_enable = ($urandom_range(0, 7) != 0);
      pop_pc2         = ($urandom_range(0, 11) == 0);
      pop_pc1         = ($urandom_range(0, 11) == 0);
      pop_data        = 16'($urandom);
      if ($urandom_range(0, 9) == 0) int_req = ~int_req;
      int_ack         = ($urandom_range(0, 5) == 0);
      step();
    end
    set_idle();
    int_req = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Reset mid-jump at PC 0x104 aborts at once and restarts the boot.
    pc_sel = 2'b11; jump_target = 32'h104;
    step();
    check("pre-reset pc", imem_addr, 32'h104);
    jump_target = 32'h200; flush_fetch = 1'b1;
    rst = 1'b1;
    #1;
    check("reset pc", imem_addr, 32'h0);
    check("reset instr", if_id_instr, 16'h0000);
    check("reset busy", boot_busy, 1'b1);
    step();
    rst = 1'b0;
    set_idle();
    step();
    step();
    check("reboot pc", imem_addr, 32'h20);
    step();
    step();

    @(negedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage feeding the decode/control unit. Owns the 32-bit PC, the boot sequence that loads the reset vector from instruction memory, the PC source selection driven by the control unit's `pc_sel`, `fetch_pc_enable`, `pop_pc2`/`pop_pc1` and `flush_fetch`, and the IF/ID pipeline register that supplies `opCode`. It also latches the external interrupt request into a pending flag for the interrupt state machine.

## Interface
- `INT_VECTOR`, 32'h0000_0010, PC loaded when `pc_sel` = 2'b10.
- `NOP_WORD`, 16'h0000, instruction injected on flush; opcode field 5'b00000.
- `clk` in 1: single clock; every register updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc_sel` in 2: 00 sequential, 01 restart boot, 10 interrupt vector, 11 jump target.
- `jump_target` in 32: branch/call target, used when `pc_sel` = 11.
- `fetch_pc_enable` in 1: 0 holds the PC.
- `freeze_cu` in 1: holds the IF/ID register.
- `flush_fetch` in 1: replaces the IF/ID contents with `NOP_WORD`.
- `pop_pc2` in 1: captures `pop_data` as PC[31:16].
- `pop_pc1` in 1: loads PC = {staged_hi, `pop_data`}.
- `pop_data` in 16: data-memory read word used by pops.
- `imem_addr` out 32: instruction memory address, equal to the PC.
- `imem_data` in 16: combinational read data at `imem_addr`.
- `int_req` in 1: asynchronous external interrupt pin.
- `int_ack` in 1: one-cycle pulse from the interrupt SM that clears pending.
- `int_pending` out 1: latched interrupt request.
- `if_id_instr` out 16: registered instruction word.
- `opCode` out 5: `if_id_instr[15:11]`.
- `if_id_pc_next` out 32: PC+1 of the registered instruction (call push value).
- `boot_busy` out 1: high while the boot FSM runs.

## Operation
- Boot FSM states: BOOT_HI, BOOT_LO, RUN.
  - Reset enters BOOT_HI with PC = 0.
  - BOOT_HI: `imem_addr` = 0; captures `imem_data` into staged_hi; PC <= 1; goes to BOOT_LO.
  - BOOT_LO: PC <= {staged_hi, `imem_data`}; goes to RUN.
  - RUN: normal fetch.
  - In RUN, `pc_sel` = 01 sets PC <= 0 and enters BOOT_HI.
- PC update in RUN, highest priority first:
  1. `pop_pc1` → {staged_hi, `pop_data`}
  2. `pc_sel` = 11 → `jump_target`
  3. `pc_sel` = 10 → `INT_VECTOR`
  4. `pc_sel` = 01 → 0 (reboot)
  5. `fetch_pc_enable` = 0 → hold
  6. otherwise PC + 1
  - `pop_pc1` and the `pc_sel` loads override `fetch_pc_enable` = 0, because the ret/rti SMs pop while the PC is frozen.
- `pop_pc2` writes staged_hi in any state; it does not change the PC. The same staged_hi register is shared with the boot FSM.
- PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFF + 1 wraps to 0.
- IF/ID register, highest priority first:
  1. In BOOT_HI or BOOT_LO → `NOP_WORD`.
  2. `flush_fetch` → `NOP_WORD`, `if_id_pc_next` = 0.
  3. `freeze_cu` → hold.
  4. Otherwise load `imem_data` and PC+1.
  - `flush_fetch` beats `freeze_cu`.
- Interrupt path:
  - Rising edge detected on synchronized `int_req` sets `int_pending`.
  - `int_ack` clears `int_pending`.
  - If a new edge arrives in the same cycle as `int_ack`, `int_pending` stays 1.
  - `int_req` held high sets `int_pending` only once.
- Reset values:
  - PC = 0, staged_hi = 0, state BOOT_HI.
  - `if_id_instr` = `NOP_WORD`, `if_id_pc_next` = 0.
  - `int_pending` = 0, `boot_busy` = 1, synchronizer flops = 0.
  - Reset asserted mid-operation aborts any boot, pop or jump immediately.

## Timing
- `imem_addr` is combinational from the PC register; instruction memory is read asynchronously.
- Fetch-to-decode latency: 1 cycle. The word at PC in cycle n appears on `opCode` in cycle n+1.
- Boot: `boot_busy` deasserts 2 cycles after `rst` falls. The first real instruction is on `if_id_instr` at cycle 3.
- Jump (`pc_sel` = 11 in cycle n): the target is fetched in cycle n+1. The wrong-path word fetched in cycle n is discarded by `flush_fetch` asserted in cycle n.
- Pop sequence: `pop_pc2` in cycle n, `pop_pc1` in cycle n+1; the new PC is valid in cycle n+2.
- Interrupt latency: `int_req` rise to `int_pending` is 1 cycle without synchronizer, 3 cycles with it.

## Configuration
- `FETCH_INT_SYNC_EN` defined: `int_req` passes a two-flop synchronizer, then an edge-detect flop.
- `FETCH_INT_SYNC_EN` undefined: a single edge-detect flop samples `int_req` directly.
- Everything else is identical in both builds.

## Test plan
- Reset with mem[0] = 16'h0000, mem[1] = 16'h0020, release → `boot_busy` is 1 for 2 cycles, then PC = 32'h20, then `if_id_instr` = mem[0x20].
- Run PC 0x20..0x22, then `pc_sel` = 11 with `jump_target` = 0x100 and `flush_fetch` = 1 → `opCode` = 0 for one cycle, then mem[0x100].
- `fetch_pc_enable` = 0 with `pop_pc2`, `pop_data` = 16'h0001, next cycle `pop_pc1`, `pop_data` = 16'h0004 → PC = 32'h0001_0004.
- `freeze_cu` = 1 for 2 cycles → `if_id_instr` is held. `freeze_cu` = 1 together with `flush_fetch` = 1 → NOP.
- Pulse `int_req` → `int_pending` = 1 after 3 cycles (1 cycle with `FETCH_INT_SYNC_EN` undefined). `int_ack` clears it. `int_req` held high does not re-set it.
- Assert `rst` mid-jump while PC = 0x104 → PC = 0 and `if_id_instr` = NOP immediately; boot restarts.
